mac_accumulator: RTL and testbench
==================================

# mac_accumulator

Streaming signed accumulator that consumes two's-complement mantissa terms from the MAC's sign-to-two's-complement stage and sums one group of terms per output. The block sits directly downstream of that conversion stage. It sign-extends each WIDTH-bit term to ACC_WIDTH and keeps a running sum. It closes a group on `i_last` or when MAX_TERMS terms have been accepted, then presents the result in sign-magnitude form to the normalization stage.

## Interface
- `WIDTH`, 10: input term width, two's complement.
- `ACC_WIDTH`, 16: accumulator width, ≥ WIDTH+1.
- `MAX_TERMS`, 16: maximum terms per group, ≥ 1.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  input term valid.
- `o_ready`  out  1  block can accept a term.
- `i_mant`  in  WIDTH  two's-complement term.
- `i_last`  in  1  term is the final term of its group.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  downstream accepts the result.
- `o_sign`  out  1  result sign; 1 means negative.
- `o_mant`  out  ACC_WIDTH  result magnitude, unsigned.
- `o_cnt`  out  $clog2(MAX_TERMS+1)  number of terms in the group.
- `o_ovf`  out  1  overflow occurred within the group (sticky per group).

## Operation
- States are IDLE, ACC and HOLD.
- Accept occurs when `i_valid && o_ready`.
- `o_ready` = (state != HOLD).
- **IDLE:** on accept, acc ← sext(i_mant), cnt ← 1, ovf ← 0.
  - If the group closes on that term, go to HOLD; otherwise go to ACC.
- **ACC:** on accept, acc ← acc + sext(i_mant), cnt ← cnt+1, and ovf is updated.
  - If the group closes, go to HOLD; otherwise stay in ACC.
  - With no accept, the state holds.
- **Group close:** the group closes when `i_last` is set, or when cnt after this accept equals MAX_TERMS.
  - A term at MAX_TERMS without `i_last` still closes the group.
  - The next term starts a new group.
- **HOLD:** `o_valid` = 1.
  - Outputs stay stable while `i_ready` = 0.
  - When `o_valid && i_ready`, go to IDLE.
- **Output format:**
  - `o_sign` = acc[ACC_WIDTH-1].
  - `o_mant` = two's-complement magnitude of acc.
  - The most negative value −2^(ACC_WIDTH-1) gives o_mant = 2^(ACC_WIDTH-1), which is representable.
- **Overflow detection:** overflow exists when the operand signs are equal and the wrapped sum's sign differs. Once set, ovf stays set until the next group starts.

## Timing
- Reset values: state IDLE, acc 0, cnt 0, ovf 0, `o_valid` 0, `o_ready` 1, `o_sign` 0, `o_mant` 0, `o_cnt` 0, `o_ovf` 0.
- **Latency:** the closing term is accepted at edge N, and `o_valid` = 1 from the cycle after edge N.
- **Bubble:** the result is taken at edge M, and `o_ready` = 1 from the cycle after edge M. No term is accepted in the HOLD→IDLE transition cycle.
- Outputs are registered. `o_ready` is decoded from the state register only, with no combinational path from `i_ready`.
- `i_last` is ignored unless the term is accepted.
- `i_valid` while in HOLD has no effect. Upstream holds the term.
- Asserting `i_rst_n` low in any state (mid-group or mid-HOLD) clears immediately. A partial group is discarded and no result is produced.

## Configuration
- Macro: `MAC_ACC_SAT_EN`.
- **Defined:** on overflow, acc clamps to +(2^(ACC_WIDTH-1)−1) or −2^(ACC_WIDTH-1), matching the sign of the operands. Later terms add to the clamped value. `o_ovf` is set.
- **Undefined:** acc wraps modulo 2^ACC_WIDTH. `o_ovf` is still reported.

## Structure
- Package `mac_pkg` holds:
  - the state enum `mac_acc_state_e` (IDLE, ACC, HOLD);
  - `MAC_ACC_WIDTH_DEF` = 16;
  - `MAC_MAX_TERMS_DEF` = 16.
- Sub-module: one instance of `mac_2s_complement` with WIDTH = ACC_WIDTH. It is driven by acc and its sign bit and produces `o_mant`.

## Test plan
1. WIDTH=10, ACC=16, all defaults. Send 5, 10'h3FD (−3), then 7 with last → o_valid one cycle later, o_sign=0, o_mant=9, o_cnt=3, o_ovf=0.
2. Send −100 then −200 with last → o_sign=1, o_mant=300, o_cnt=2.
3. ACC_WIDTH=12. Send 511 ×5, with last on the fifth term.
   - Without the macro: wrapped −1541, so o_sign=1, o_mant=1541, o_ovf=1.
   - With `MAC_ACC_SAT_EN`: o_sign=0, o_mant=2047, o_ovf=1.
4. MAX_TERMS=4. Send 1,1,1,1 with no last, then 2 with last → first result o_mant=4, o_cnt=4. Second result o_mant=2, o_cnt=1.
5. Hold `i_ready`=0 for 5 cycles after a result → outputs stay stable and `o_ready`=0. Raise `i_ready` → o_valid drops next cycle, and the next term is accepted one cycle after that.
6. Send 3,3, then pull `i_rst_n` low mid-group. Release it, then send 4 with last → result o_mant=4, o_cnt=1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC accumulator stage.
// The optional saturating mode is selected with the MAC_ACC_SAT_EN macro.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } mac_acc_state_e;

  localparam int MAC_ACC_WIDTH_DEF = 16;
  localparam int MAC_MAX_TERMS_DEF = 16;

endpackage

// File: rtl/mac_2s_complement.sv
// Two's-complement to magnitude conversion; the most negative input maps to
// 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
module mac_2s_complement #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic             sign,
  output logic [WIDTH-1:0] mag
);

  assign mag = sign ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mac_accumulator.sv
// Streaming signed group accumulator with sign-magnitude result hand-off.
// Define MAC_ACC_SAT_EN to clamp the running sum on overflow instead of wrapping.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int ACC_WIDTH = MAC_ACC_WIDTH_DEF,
  parameter int MAX_TERMS = MAC_MAX_TERMS_DEF,
  localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_mant,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_sign,
  output logic [ACC_WIDTH-1:0] o_mant,
  output logic [CNT_W-1:0]     o_cnt,
  output logic                 o_ovf
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MAX_TERMS);
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

  mac_acc_state_e         state_reg;
  logic [ACC_WIDTH-1:0]   acc_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   ovf_reg;

  logic                   accept;
  logic [ACC_WIDTH-1:0]   term_ext;
  logic [ACC_WIDTH-1:0]   sum_wrap;
  logic [ACC_WIDTH-1:0]   sum_next;
  logic                   add_ovf;
  logic [CNT_W-1:0]       cnt_inc;

  assign accept   = i_valid && o_ready;
  assign term_ext = {{(ACC_WIDTH-WIDTH){i_mant[WIDTH-1]}}, i_mant};
  assign cnt_inc  = cnt_reg + CNT_ONE;

  always_comb begin
    sum_wrap = acc_reg + term_ext;
    // Only same-sign operands can overflow; a sign flip in the wrapped sum marks it.
    add_ovf  = (acc_reg[ACC_WIDTH-1] == term_ext[ACC_WIDTH-1]) &&
               (sum_wrap[ACC_WIDTH-1] != acc_reg[ACC_WIDTH-1]);
    sum_next = sum_wrap;
`ifdef MAC_ACC_SAT_EN
    if (add_ovf) begin
      sum_next = term_ext[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end
`else
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_reg   <= term_ext;
            cnt_reg   <= CNT_ONE;
            ovf_reg   <= 1'b0;
            state_reg <= (i_last || (CNT_ONE == CNT_MAX)) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc_reg   <= sum_next;
            cnt_reg   <= cnt_inc;
            ovf_reg   <= ovf_reg | add_ovf;
            state_reg <= (i_last || (cnt_inc == CNT_MAX)) ? HOLD : ACC;
          end
        end
        HOLD: begin
          if (i_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register alone, so i_ready never reaches o_ready.
  assign o_ready = (state_reg != HOLD);
  assign o_valid = (state_reg == HOLD);
  assign o_sign  = acc_reg[ACC_WIDTH-1];
  assign o_cnt   = cnt_reg;
  assign o_ovf   = ovf_reg;

  mac_2s_complement #(
    .WIDTH (ACC_WIDTH)
  ) u_mag (
    .value (acc_reg),
    .sign  (acc_reg[ACC_WIDTH-1]),
    .mag   (o_mant)
  );

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: dut0 has a 12-bit accumulator (overflow
// cases), dut1 has MAX_TERMS=4 (forced group close).
module tb_mac_accumulator;

  logic        clk;
  logic        rst_n;
  logic        valid0, valid1;
  logic [9:0]  mant;
  logic        last;
  logic        rdy_in;

  logic        ready0, ovalid0, sign0, ovf0;
  logic [11:0] omant0;
  logic [4:0]  cnt0;
  logic        ready1, ovalid1, sign1, ovf1;
  logic [15:0] omant1;
  logic [2:0]  cnt1;

  bit          sel;
  int          n_applied = 0;
  int          n_fail    = 0;

  mac_accumulator #(.WIDTH(10), .ACC_WIDTH(12), .MAX_TERMS(16)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid0), .o_ready(ready0),
    .i_mant(mant), .i_last(last), .o_valid(ovalid0), .i_ready(rdy_in),
    .o_sign(sign0), .o_mant(omant0), .o_cnt(cnt0), .o_ovf(ovf0)
  );

  mac_accumulator #(.WIDTH(10), .ACC_WIDTH(16), .MAX_TERMS(4)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid1), .o_ready(ready1),
    .i_mant(mant), .i_last(last), .o_valid(ovalid1), .i_ready(rdy_in),
    .o_sign(sign1), .o_mant(omant1), .o_cnt(cnt1), .o_ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          s;
    logic [9:0]  m;
    bit          l;
    bit          close;
    bit          sg;
    int unsigned mg;
    int unsigned cn;
    bit          ov;
  } vec_t;

  vec_t vecs[$];

  function automatic logic get_ready();  return sel ? ready1  : ready0;  endfunction
  function automatic logic get_valid();  return sel ? ovalid1 : ovalid0; endfunction
  function automatic logic get_sign();   return sel ? sign1   : sign0;   endfunction
  function automatic logic get_ovf();    return sel ? ovf1    : ovf0;    endfunction
  function automatic logic [31:0] get_mant(); return sel ? 32'(omant1) : 32'(omant0); endfunction
  function automatic logic [31:0] get_cnt();  return sel ? 32'(cnt1)   : 32'(cnt0);   endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit s, input logic [9:0] m, input bit l, input bit c,
                     input bit sg, input int unsigned mg, input int unsigned cn, input bit ov);
    vec_t v;
    v.s = s; v.m = m; v.l = l; v.close = c; v.sg = sg; v.mg = mg; v.cn = cn; v.ov = ov;
    vecs.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input bit s, input logic [9:0] m, input bit l);
    int waited;
    waited = 0;
    sel = s;
    mant = m;
    last = l;
    if (s) valid1 = 1'b1; else valid0 = 1'b1;
    while (!get_ready() && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!get_ready()) begin
      n_applied++;
      n_fail++;
      $display("FAIL send_timeout: o_ready stuck at 0 for term %0d", m);
    end
    @(negedge clk);
    valid0 = 1'b0;
    valid1 = 1'b0;
    last   = 1'b0;
  endtask

  task automatic consume();
    rdy_in = 1'b1;
    @(negedge clk);
    rdy_in = 1'b0;
    check("drain_o_valid", 32'(get_valid()), 32'd0);
    check("drain_o_ready", 32'(get_ready()), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    mant = '0; last = 1'b0; rdy_in = 1'b0; sel = 1'b0;

    // Test 3 expectations depend on whether the sum wraps or clamps.
`ifdef MAC_ACC_SAT_EN
    add(0, 10'h1FF, 0, 0, 0, 0, 0, 0);
    add(0, 10'h1FF, 0, 0, 0, 0, 0, 0);
    add(0, 10'h1FF, 0, 0, 0, 0, 0, 0);
    add(0, 10'h1FF, 0, 0, 0, 0, 0, 0);
    add(0, 10'h1FF, 1, 1, 0, 2047, 5, 1);
`else
    add(0, 10'h1FF, 0, 0, 0, 0, 0, 0);
    add(0, 10'h1FF, 0, 0, 0, 0, 0, 0);
    add(0, 10'h1FF, 0, 0, 0, 0, 0, 0);
    add(0, 10'h1FF, 0, 0, 0, 0, 0, 0);
    add(0, 10'h1FF, 1, 1, 1, 1541, 5, 1);
`endif
    add(0, 10'd1,   1, 1, 0, 1, 1, 0);          // ovf cleared by new group
    add(0, 10'd5,   0, 0, 0, 0, 0, 0);          // test 1
    add(0, 10'h3FD, 0, 0, 0, 0, 0, 0);
    add(0, 10'd7,   1, 1, 0, 9, 3, 0);
    add(0, 10'h39C, 0, 0, 0, 0, 0, 0);          // test 2: -100, -200
    add(0, 10'h338, 1, 1, 1, 300, 2, 0);
    add(0, 10'h200, 0, 0, 0, 0, 0, 0);          // -512 x4 = most negative, exact
    add(0, 10'h200, 0, 0, 0, 0, 0, 0);
    add(0, 10'h200, 0, 0, 0, 0, 0, 0);
    add(0, 10'h200, 1, 1, 1, 2048, 4, 0);
    add(0, 10'h200, 0, 0, 0, 0, 0, 0);          // -512 x5: negative overflow
    add(0, 10'h200, 0, 0, 0, 0, 0, 0);
    add(0, 10'h200, 0, 0, 0, 0, 0, 0);
    add(0, 10'h200, 0, 0, 0, 0, 0, 0);
`ifdef MAC_ACC_SAT_EN
    add(0, 10'h200, 1, 1, 1, 2048, 5, 1);
`else
    add(0, 10'h200, 1, 1, 0, 1536, 5, 1);
`endif
    add(1, 10'd1,   0, 0, 0, 0, 0, 0);          // test 4 on dut1
    add(1, 10'd1,   0, 0, 0, 0, 0, 0);
    add(1, 10'd1,   0, 0, 0, 0, 0, 0);
    add(1, 10'd1,   0, 1, 0, 4, 4, 0);
    add(1, 10'd2,   1, 1, 0, 2, 1, 0);
    add(1, 10'h3FD, 1, 1, 1, 3, 1, 0);

    #12;
    for (int d = 0; d < 2; d++) begin
      sel = bit'(d);
      check("rst_o_valid", 32'(get_valid()), 32'd0);
      check("rst_o_ready", 32'(get_ready()), 32'd1);
      check("rst_o_sign",  32'(get_sign()),  32'd0);
      check("rst_o_mant",  get_mant(),       32'd0);
      check("rst_o_cnt",   get_cnt(),        32'd0);
      check("rst_o_ovf",   32'(get_ovf()),   32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].s, vecs[i].m, vecs[i].l);
      check($sformatf("v%0d_o_valid", i), 32'(get_valid()), 32'(vecs[i].close));
      if (vecs[i].close) begin
        check($sformatf("v%0d_o_sign", i), 32'(get_sign()), 32'(vecs[i].sg));
        check($sformatf("v%0d_o_mant", i), get_mant(), vecs[i].mg);
        check($sformatf("v%0d_o_cnt", i),  get_cnt(), vecs[i].cn);
        check($sformatf("v%0d_o_ovf", i),  32'(get_ovf()), 32'(vecs[i].ov));
        consume();
      end
      $display("vec %0d: dut%0d term=%h last=%0d o_valid=%0d", i, vecs[i].s, vecs[i].m,
               vecs[i].l, get_valid());
    end

    // HOLD back-pressure: stable outputs, o_ready low, upstream term waits.
    send(0, 10'd8, 1);
    sel = 1'b0;
    mant = 10'd6; last = 1'b1; valid0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_o_valid", 32'(get_valid()), 32'd1);
      check("hold_o_ready", 32'(get_ready()), 32'd0);
      check("hold_o_mant",  get_mant(), 32'd8);
      check("hold_o_cnt",   get_cnt(),  32'd1);
    end
    rdy_in = 1'b1;
    @(negedge clk);
    rdy_in = 1'b0;
    check("bubble_o_valid", 32'(get_valid()), 32'd0);
    check("bubble_o_ready", 32'(get_ready()), 32'd1);
    @(negedge clk);
    valid0 = 1'b0; last = 1'b0;
    check("after_bubble_o_valid", 32'(get_valid()), 32'd1);
    check("after_bubble_o_mant",  get_mant(), 32'd6);
    check("after_bubble_o_cnt",   get_cnt(),  32'd1);
    consume();
    $display("hold/bubble sequence done");

    // Asynchronous reset mid-group discards the partial sum.
    send(0, 10'd3, 0);
    send(0, 10'd3, 0);
    check("midgroup_cnt", get_cnt(), 32'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt",   get_cnt(),  32'd0);
    check("async_rst_mant",  get_mant(), 32'd0);
    check("async_rst_valid", 32'(get_valid()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 10'd4, 1);
    check("post_rst_o_valid", 32'(get_valid()), 32'd1);
    check("post_rst_o_mant",  get_mant(), 32'd4);
    check("post_rst_o_cnt",   get_cnt(),  32'd1);
    consume();
    $display("mid-group reset sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule
